tcvc_traffic_gen: RTL and testbench

Programmable traffic source that drives the write side of the interconnect's Main FIFO. It replaces the probador's hand-written Main_wr/Main_data_in stimulus.
It emits a burst of num_words 6-bit words. Each word carries a VC-id bit, a destination bit and a 4-bit payload, and the generator throttles itself on the Main FIFO status flags.
It sits upstream of the interconnect, in the same clock domain.

---
 rtl/tcvc_traffic_gen_if.sv | 24 ++
 rtl/tcvc_traffic_gen.sv | 175 +++++++++++++++++
 tb/tb_tcvc_traffic_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcvc_traffic_gen_if.sv
// Write-side bundle of the interconnect's Main FIFO: strobe and word toward the
// FIFO, status flags back to the traffic source.
interface tcvc_traffic_gen_if #(
   parameter int BW = 6
);
   logic          Main_wr;
   logic [BW-1:0] Main_data_in;
   logic          Main_full;
   logic          Main_almost_full;

   modport master (
      output Main_wr,
      output Main_data_in,
      input  Main_full,
      input  Main_almost_full
   );

   modport slave (
      input  Main_wr,
      input  Main_data_in,
      output Main_full,
      output Main_almost_full
   );
endinterface

// File: rtl/tcvc_traffic_gen.sv
// Programmable burst source for the Main FIFO write port. Words are {vc, dest, payload}
// and the write gate is throttled by the (registered) FIFO status flags.
//
//   state  | meaning
//   IDLE   | waiting for start; burst parameters latched on start
//   SEND   | one write decision per cycle while the flags are clear
//   HOLD   | backpressure seen; wait for both flags low
//   DONE   | one-cycle completion pulse, then IDLE
module tcvc_traffic_gen #(
   parameter int BW   = 6,
   parameter int CNTW = 8
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                start,
   input  logic                abort,
   input  logic [CNTW-1:0]     num_words,
   input  logic [1:0]          vc_mode,
   input  logic [1:0]          dest_mode,
   input  logic [3:0]          payload_seed,
   tcvc_traffic_gen_if.master  main_if,
   output logic                busy,
   output logic                done,
   output logic [CNTW-1:0]     words_sent
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] LFSR_INIT = 4'b1001;

   state_t          state_q, state_d;
   logic [CNTW-1:0] num_q, num_d;
   logic [CNTW-1:0] sent_q, sent_d;
   logic [1:0]      vc_mode_q, vc_mode_d;
   logic [1:0]      dest_mode_q, dest_mode_d;
   logic [3:0]      payload_q, payload_d;
   logic [3:0]      lfsr_q, lfsr_d;
   logic            alt_q, alt_d;
   logic            stall_q, stall_d;
   logic            wr_q, wr_d;
   logic [BW-1:0]   data_q, data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            vc_bit, dest_bit;

   always_comb begin
      vc_bit = 1'b0;
      case (vc_mode_q)
         2'b00:   vc_bit = 1'b0;
         2'b01:   vc_bit = 1'b1;
         2'b10:   vc_bit = alt_q;
         default: vc_bit = lfsr_q[0];
      endcase
   end

   always_comb begin
      dest_bit = 1'b0;
      case (dest_mode_q)
         2'b00:   dest_bit = 1'b0;
         2'b01:   dest_bit = 1'b1;
         2'b10:   dest_bit = alt_q;
         default: dest_bit = lfsr_q[3];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      sent_d      = sent_q;
      vc_mode_d   = vc_mode_q;
      dest_mode_d = dest_mode_q;
      payload_d   = payload_q;
      lfsr_d      = lfsr_q;
      alt_d       = alt_q;
      wr_d        = 1'b0;
      data_d      = data_q;
      // Flags are registered before gating, so one write may still follow a rising flag.
      stall_d     = main_if.Main_full | main_if.Main_almost_full;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sent_d = '0;
               if (num_words != '0) begin
                  num_d       = num_words;
                  vc_mode_d   = vc_mode;
                  dest_mode_d = dest_mode;
                  payload_d   = payload_seed;
                  lfsr_d      = LFSR_INIT;
                  alt_d       = 1'b0;
                  state_d     = S_SEND;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SEND: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (sent_q == num_q) begin
               state_d = S_DONE;
            end else if (stall_q) begin
               state_d = S_HOLD;
            end else begin
               wr_d      = 1'b1;
               data_d    = {vc_bit, dest_bit, payload_q};
               sent_d    = sent_q + CNTW'(1);
               payload_d = payload_q + 4'd1;
               alt_d     = ~alt_q;
               lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
            end
         end
         S_HOLD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!stall_q) begin
               state_d = S_SEND;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_SEND) || (state_d == S_HOLD);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= S_IDLE;
         num_q       <= '0;
         sent_q      <= '0;
         vc_mode_q   <= 2'b00;
         dest_mode_q <= 2'b00;
         payload_q   <= 4'h0;
         lfsr_q      <= LFSR_INIT;
         alt_q       <= 1'b0;
         stall_q     <= 1'b0;
         wr_q        <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         sent_q      <= sent_d;
         vc_mode_q   <= vc_mode_d;
         dest_mode_q <= dest_mode_d;
         payload_q   <= payload_d;
         lfsr_q      <= lfsr_d;
         alt_q       <= alt_d;
         stall_q     <= stall_d;
         wr_q        <= wr_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign main_if.Main_wr      = wr_q;
   assign main_if.Main_data_in = data_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign words_sent           = sent_q;

endmodule

// File: tb/tb_tcvc_traffic_gen.sv
// Bench for tcvc_traffic_gen: directed vector table, abort/reset sequences and
// random bursts under random backpressure checked against a word-index model.
module tb_tcvc_traffic_gen;
   localparam int BW   = 6;
   localparam int CNTW = 8;

   logic            clk = 1'b0;
   logic            reset_L = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [CNTW-1:0] num_words = '0;
   logic [1:0]      vc_mode = 2'b00;
   logic [1:0]      dest_mode = 2'b00;
   logic [3:0]      payload_seed = 4'h0;
   logic            busy;
   logic            done;
   logic [CNTW-1:0] words_sent;

   int total = 0;
   int bad   = 0;

   tcvc_traffic_gen_if #(.BW(BW)) mif ();

   tcvc_traffic_gen #(.BW(BW), .CNTW(CNTW)) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .start        (start),
      .abort        (abort),
      .num_words    (num_words),
      .vc_mode      (vc_mode),
      .dest_mode    (dest_mode),
      .payload_seed (payload_seed),
      .main_if      (mif),
      .busy         (busy),
      .done         (done),
      .words_sent   (words_sent)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              n;
      logic [1:0]      vcm;
      logic [1:0]      dm;
      logic [3:0]      seed;
      int              fmode;   // 0 quiet, 2 almost_full stall, 3 start while busy
      logic [0:7][5:0] ew;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Word i of a burst, straight from the word-layout and mode rules.
   function automatic logic [5:0] model_word(input int i, input logic [1:0] vcm,
                                             input logic [1:0] dm, input logic [3:0] seed);
      logic [3:0] l;
      logic       alt, v, d;
      l = 4'b1001;
      for (int k = 0; k < i; k++) l = {l[2:0], l[3] ^ l[2]};
      alt = ((i % 2) == 1);
      case (vcm)
         2'b00:   v = 1'b0;
         2'b01:   v = 1'b1;
         2'b10:   v = alt;
         default: v = l[0];
      endcase
      case (dm)
         2'b00:   d = 1'b0;
         2'b01:   d = 1'b1;
         2'b10:   d = alt;
         default: d = l[3];
      endcase
      return {v, d, 4'(int'(seed) + i)};
   endfunction

   task automatic run_burst(input string tag, input int n, input logic [1:0] vcm,
                            input logic [1:0] dm, input logic [3:0] seed,
                            input int fmode, input logic [5:0] expw[$]);
      logic [5:0] got[$];
      int         wcyc[$];
      int         flg[$];
      int         done_cyc = -1;
      int         done_cnt = 0;
      int         stall_at = -1;
      int         extra = 0;
      int         busy1 = -1;
      int         limit = n * 10 + 40;

      @(posedge clk); #1;
      start        = 1'b1;
      num_words    = CNTW'(n);
      vc_mode      = vcm;
      dest_mode    = dm;
      payload_seed = seed;
      mif.Main_full        = 1'b0;
      mif.Main_almost_full = 1'b0;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         flg.push_back(int'(mif.Main_full | mif.Main_almost_full));
         if (mif.Main_wr) begin
            got.push_back(mif.Main_data_in);
            wcyc.push_back(c);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 1) busy1 = int'(busy);
         if (fmode == 2 && stall_at < 0 && got.size() == 2) stall_at = c + 1;
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         @(posedge clk); #1;
         start = (fmode == 3) && (c + 1 == 2 || c + 1 == 3);
         if (start) begin
            num_words = 8'd1;
            vc_mode   = 2'b01;
         end
         case (fmode)
            1: begin
               mif.Main_almost_full = ($urandom_range(0, 3) == 0);
               mif.Main_full        = ($urandom_range(0, 7) == 0);
            end
            2: mif.Main_almost_full = (stall_at >= 0) && (c + 1 >= stall_at) && (c + 1 < stall_at + 3);
            default: ;
         endcase
      end
      start                = 1'b0;
      mif.Main_full        = 1'b0;
      mif.Main_almost_full = 1'b0;

      check({tag, ".done_seen"}, int'(done_cyc >= 0), 1);
      check({tag, ".done_pulses"}, done_cnt, 1);
      check({tag, ".wr_count"}, got.size(), expw.size());
      for (int i = 0; i < got.size() && i < expw.size(); i++)
         check($sformatf("%s.data%0d", tag, i), int'(got[i]), int'(expw[i]));
      if (n == 0) check({tag, ".done_at"}, done_cyc, 1);
      else if (wcyc.size() > 0) check({tag, ".done_after_last"}, done_cyc, wcyc[wcyc.size()-1] + 1);
      check({tag, ".busy_c1"}, busy1, (n > 0) ? 1 : 0);
      if ((fmode == 0 || fmode == 3) && n > 0 && wcyc.size() == n) begin
         check({tag, ".first_wr_cycle"}, wcyc[0], 2);
         check({tag, ".last_wr_cycle"}, wcyc[n-1], n + 1);
      end
      for (int i = 0; i < wcyc.size(); i++)
         check($sformatf("%s.flow%0d", tag, i),
               (wcyc[i] >= 2) ? flg[wcyc[i]-2] : 1, 0);
      if (fmode == 2) begin
         check({tag, ".stall_applied"}, int'(stall_at >= 0), 1);
         for (int i = 0; i < wcyc.size(); i++)
            if (wcyc[i] > stall_at && wcyc[i] <= stall_at + 4) extra++;
         check({tag, ".stall_extra_le1"}, int'(extra <= 1), 1);
      end
      check({tag, ".words_sent"}, int'(words_sent), n);
      check({tag, ".busy_end"}, int'(busy), 0);
   endtask

   task automatic abort_test();
      int nw = 0;
      int wr_seen = 0;
      int done_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; num_words = 8'd10; vc_mode = 2'b00; dest_mode = 2'b00; payload_seed = 4'h0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 20 && nw < 3; k++) begin
         @(negedge clk);
         if (mif.Main_wr) nw++;
      end
      check("abort.reached3", nw, 3);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort.wr_next", int'(mif.Main_wr), 0);
      check("abort.busy", int'(busy), 0);
      check("abort.done", int'(done), 0);
      check("abort.words_sent", int'(words_sent), 3);
      repeat (6) begin
         @(negedge clk);
         wr_seen   += int'(mif.Main_wr);
         done_seen += int'(done);
      end
      check("abort.no_wr_after", wr_seen, 0);
      check("abort.no_done", done_seen, 0);
      check("abort.words_hold", int'(words_sent), 3);
   endtask

   task automatic reset_test();
      int nw = 0;
      int wr_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; num_words = 8'd10; vc_mode = 2'b01; dest_mode = 2'b01; payload_seed = 4'h5;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 20 && nw < 2; k++) begin
         @(negedge clk);
         if (mif.Main_wr) nw++;
      end
      check("rst.reached2", nw, 2);
      reset_L = 1'b0;
      #1;
      check("rst.wr", int'(mif.Main_wr), 0);
      check("rst.data", int'(mif.Main_data_in), 0);
      check("rst.busy", int'(busy), 0);
      check("rst.done", int'(done), 0);
      check("rst.words_sent", int'(words_sent), 0);
      @(negedge clk);
      reset_L = 1'b1;
      repeat (5) begin
         @(negedge clk);
         wr_seen += int'(mif.Main_wr) + int'(busy);
      end
      check("rst.idle_after", wr_seen, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] eq[$];
      logic [1:0] rv, rd;
      logic [3:0] rs;
      int         rn;

      mif.Main_full        = 1'b0;
      mif.Main_almost_full = 1'b0;

      vecs[0] = '{n: 4, vcm: 2'b00, dm: 2'b00, seed: 4'hE, fmode: 0,
                  ew: {6'h0E, 6'h0F, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00}};
      vecs[1] = '{n: 4, vcm: 2'b10, dm: 2'b10, seed: 4'h0, fmode: 0,
                  ew: {6'h00, 6'h31, 6'h02, 6'h33, 6'h00, 6'h00, 6'h00, 6'h00}};
      vecs[2] = '{n: 5, vcm: 2'b11, dm: 2'b11, seed: 4'h3, fmode: 0,
                  ew: {6'h33, 6'h24, 6'h05, 6'h36, 6'h17, 6'h00, 6'h00, 6'h00}};
      vecs[3] = '{n: 3, vcm: 2'b01, dm: 2'b10, seed: 4'hF, fmode: 0,
                  ew: {6'h2F, 6'h30, 6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00}};
      vecs[4] = '{n: 0, vcm: 2'b00, dm: 2'b00, seed: 4'h0, fmode: 0,
                  ew: {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00}};
      vecs[5] = '{n: 5, vcm: 2'b00, dm: 2'b01, seed: 4'h7, fmode: 3,
                  ew: {6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h00, 6'h00}};
      vecs[6] = '{n: 6, vcm: 2'b10, dm: 2'b00, seed: 4'hC, fmode: 2,
                  ew: {6'h0C, 6'h2D, 6'h0E, 6'h2F, 6'h00, 6'h21, 6'h00, 6'h00}};

      #12;
      check("reset.wr", int'(mif.Main_wr), 0);
      check("reset.data", int'(mif.Main_data_in), 0);
      check("reset.busy", int'(busy), 0);
      check("reset.done", int'(done), 0);
      check("reset.words_sent", int'(words_sent), 0);
      @(negedge clk);
      reset_L = 1'b1;

      for (int v = 0; v < 7; v++) begin
         eq = {};
         for (int i = 0; i < vecs[v].n; i++) eq.push_back(vecs[v].ew[i]);
         run_burst($sformatf("vec%0d", v), vecs[v].n, vecs[v].vcm, vecs[v].dm,
                   vecs[v].seed, vecs[v].fmode, eq);
      end

      abort_test();
      reset_test();

      for (int r = 0; r < 12; r++) begin
         rn = $urandom_range(0, 20);
         rv = 2'($urandom_range(0, 3));
         rd = 2'($urandom_range(0, 3));
         rs = 4'($urandom_range(0, 15));
         eq = {};
         for (int i = 0; i < rn; i++) eq.push_back(model_word(i, rv, rd, rs));
         run_burst($sformatf("rnd%0d", r), rn, rv, rd, rs, 1, eq);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
